// File: rtl/mem_access.sv
// Pipeline M stage with a handshaked data-memory port: captures E-stage controls,
// holds the pipe while a load/store is outstanding and aborts it after TIMEOUT cycles.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallM,
    input  logic        flushM,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        jumpE,
    input  logic [3:0]  MemtoRegE,
    input  logic [4:0]  WriteRegE,
    input  logic [31:0] ALUMultOutE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCPlus8E,
    output logic        RegWriteM,
    output logic        jumpM,
    output logic [3:0]  MemtoRegM,
    output logic [4:0]  WriteRegM,
    output logic [31:0] ReadDataM,
    output logic [31:0] ALUMultOutM,
    output logic [31:0] PCPlus8M,
    output logic        memBusyM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          reg_write_q, reg_write_d;
    logic          mem_write_q, mem_write_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          busy_q, busy_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          capture;

    logic          jump_q;
    logic [3:0]    mem_to_reg_q;
    logic [4:0]    write_reg_q;
    logic [31:0]   alu_q, wdata_q, pc8_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;
        read_data_d = read_data_q;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                // Busy is low only in IDLE, so this is the only place a capture can happen.
                if (!stallM) begin
                    capture     = 1'b1;
                    reg_write_d = RegWriteE & ~flushM;
                    mem_write_d = MemWriteE & ~flushM;
                    cnt_d       = '0;
                    if (!flushM && (MemtoRegE[1:0] == 2'b11 || MemWriteE))
                        state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    if (mem_to_reg_q[1:0] == 2'b11)
                        read_data_d = dmem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ERROR;
                    reg_write_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERROR: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        req_d  = (state_d == ACCESS);
        we_d   = (state_d == ACCESS) && mem_write_d;
        err_d  = (state_d == ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state logic lives in always_comb.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            read_data_q <= '0;
            busy_q      <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            read_data_q <= read_data_d;
            busy_q      <= busy_d;
            req_q       <= req_d;
            we_q        <= we_d;
            err_q       <= err_d;
        end
    end

    // NOTE: pure datapath registers carry no reset; they are meaningless until the first capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            jump_q       <= jumpE;
            mem_to_reg_q <= MemtoRegE;
            write_reg_q  <= WriteRegE;
            alu_q        <= ALUMultOutE;
            wdata_q      <= WriteDataE;
            pc8_q        <= PCPlus8E;
        end
    end

    assign RegWriteM   = reg_write_q & ~busy_q;
    assign jumpM       = jump_q;
    assign MemtoRegM   = mem_to_reg_q;
    assign WriteRegM   = write_reg_q;
    assign ReadDataM   = read_data_q;
    assign ALUMultOutM = alu_q;
    assign PCPlus8M    = pc8_q;
    assign memBusyM    = busy_q;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = alu_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_err    = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, reset-mid-access sequence,
// and randomized instructions compared with a transaction-level reference model.
module tb_mem_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallM, flushM, RegWriteE, MemWriteE, jumpE;
    logic [3:0]  MemtoRegE;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUMultOutE, WriteDataE, PCPlus8E;
    logic        RegWriteM, jumpM;
    logic [3:0]  MemtoRegM;
    logic [4:0]  WriteRegM;
    logic [31:0] ReadDataM, ALUMultOutM, PCPlus8M;
    logic        memBusyM, dmem_req, dmem_we, dmem_err, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .stallM(stallM), .flushM(flushM),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .jumpE(jumpE),
        .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE), .ALUMultOutE(ALUMultOutE),
        .WriteDataE(WriteDataE), .PCPlus8E(PCPlus8E),
        .RegWriteM(RegWriteM), .jumpM(jumpM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ReadDataM(ReadDataM), .ALUMultOutM(ALUMultOutM), .PCPlus8M(PCPlus8M),
        .memBusyM(memBusyM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall, flush, noise;
        bit          rw, mw, jmp;
        logic [3:0]  mtr;
        logic [4:0]  wr;
        logic [31:0] alu, wd, pc8, rdata;
        int          delay;              // ack on this busy cycle; 0 = never
    } op_t;

    typedef struct {
        op_t         op;
        int          e_busy, e_req, e_err;
        bit          e_rw;
        logic [31:0] e_rd;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_rw;
    logic [31:0] m_rd;
    bit          m_valid;
    op_t         m_op;
    int          x_busy, x_req, x_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level outcome of one instruction, straight from the stage rules.
    task automatic model(input op_t op);
        bit is_mem;
        x_busy = 0; x_req = 0; x_err = 0;
        if (op.stall) return;
        m_rw    = op.rw && !op.flush;
        m_valid = !op.flush;
        m_op    = op;
        is_mem  = !op.flush && (op.mtr[1:0] == 2'b11 || op.mw);
        if (!is_mem) return;
        if (op.delay >= 1 && op.delay <= TO) begin
            x_busy = op.delay;
            x_req  = op.delay;
            if (op.mtr[1:0] == 2'b11) m_rd = op.rdata;
        end else begin
            x_busy = TO + 1;
            x_req  = TO;
            x_err  = 1;
            m_rw   = 1'b0;
        end
    endtask

    task automatic do_op(input op_t op, output int busy_n, output int req_n, output int err_n);
        RegWriteE = op.rw; MemWriteE = op.mw; jumpE = op.jmp; MemtoRegE = op.mtr;
        WriteRegE = op.wr; ALUMultOutE = op.alu; WriteDataE = op.wd; PCPlus8E = op.pc8;
        stallM = op.stall; flushM = op.flush; dmem_ack = 1'b0; dmem_rdata = op.rdata;
        step();
        stallM = op.noise; flushM = op.noise;
        RegWriteE = ~op.rw; MemWriteE = ~op.mw; ALUMultOutE = ~op.alu; WriteDataE = ~op.wd;
        busy_n = 0; req_n = 0; err_n = 0;
        while (memBusyM === 1'b1 && busy_n < 20) begin
            busy_n++;
            if (dmem_err === 1'b1) err_n++;
            check("regwrite_masked_busy", RegWriteM, 0);
            if (dmem_req === 1'b1) begin
                req_n++;
                check("dmem_addr", dmem_addr, op.alu);
                check("dmem_we", dmem_we, op.mw);
                if (op.mw) check("dmem_wdata", dmem_wdata, op.wd);
            end else begin
                check("dmem_we_idle", dmem_we, 0);
            end
            dmem_ack = (busy_n == op.delay);
            step();
        end
        dmem_ack = 1'b0; stallM = 1'b0; flushM = 1'b0;
        check("dmem_req_after", dmem_req, 0);
        check("dmem_err_after", dmem_err, 0);
    endtask

    task automatic check_fields(input string tag);
        check({tag, "_RegWriteM"}, RegWriteM, m_rw);
        check({tag, "_ReadDataM"}, ReadDataM, m_rd);
        if (m_valid) begin
            check({tag, "_WriteRegM"}, WriteRegM, m_op.wr);
            check({tag, "_ALUMultOutM"}, ALUMultOutM, m_op.alu);
            check({tag, "_PCPlus8M"}, PCPlus8M, m_op.pc8);
            check({tag, "_MemtoRegM"}, MemtoRegM, m_op.mtr);
            check({tag, "_jumpM"}, jumpM, m_op.jmp);
        end
    endtask

    function automatic op_t mk(bit rw, bit mw, logic [3:0] mtr, logic [31:0] alu,
                               logic [31:0] wd, logic [31:0] rdata, int delay,
                               bit stall, bit flush, bit noise);
        op_t o;
        o.rw = rw; o.mw = mw; o.jmp = 1'b0; o.mtr = mtr; o.wr = 5'd9;
        o.alu = alu; o.wd = wd; o.pc8 = alu + 32'd8; o.rdata = rdata; o.delay = delay;
        o.stall = stall; o.flush = flush; o.noise = noise;
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   b, r, e;
        op_t  op;

        rst = 1'b0; stallM = 1'b0; flushM = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; jumpE = 1'b0; MemtoRegE = '0; WriteRegE = '0;
        ALUMultOutE = '0; WriteDataE = '0; PCPlus8E = '0;
        m_rw = 1'b0; m_rd = '0; m_valid = 1'b0;
        #12;
        check("rst_RegWriteM", RegWriteM, 0);
        check("rst_memBusyM", memBusyM, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_dmem_err", dmem_err, 0);
        check("rst_ReadDataM", ReadDataM, 0);
        rst = 1'b1;
        step();

        //              rw mw  mtr      alu          wd           rdata        dly st fl nz   busy req err rw rd
        vecs[0] = '{mk(1, 0, 4'b0011, 32'h100,     32'h0,       32'hDEADBEEF, 3, 0, 0, 0), 3, 3, 0, 1, 32'hDEADBEEF};
        vecs[1] = '{mk(0, 1, 4'b0000, 32'h200,     32'h12345678, 32'h0,       2, 0, 0, 0), 2, 2, 0, 0, 32'hDEADBEEF};
        vecs[2] = '{mk(1, 0, 4'b0011, 32'h300,     32'h0,       32'h11111111, 0, 0, 0, 0), 5, 4, 1, 0, 32'hDEADBEEF};
        vecs[3] = '{mk(1, 0, 4'b0111, 32'h304,     32'h0,       32'hCAFEF00D, 4, 0, 0, 0), 4, 4, 0, 1, 32'hCAFEF00D};
        vecs[4] = '{mk(1, 0, 4'b0011, 32'h308,     32'h0,       32'h22222222, 1, 0, 1, 0), 0, 0, 0, 0, 32'hCAFEF00D};
        vecs[5] = '{mk(1, 0, 4'b0011, 32'h30C,     32'h0,       32'hA5A5A5A5, 2, 0, 0, 1), 2, 2, 0, 1, 32'hA5A5A5A5};
        vecs[6] = '{mk(1, 0, 4'b0011, 32'h310,     32'h0,       32'h5A5A5A5A, 1, 0, 0, 0), 1, 1, 0, 1, 32'h5A5A5A5A};
        vecs[7] = '{mk(1, 0, 4'b0000, 32'h00000042, 32'h0,      32'h0,        0, 0, 0, 0), 0, 0, 0, 1, 32'h5A5A5A5A};
        vecs[8] = '{mk(0, 0, 4'b0001, 32'h00000077, 32'h0,      32'h0,        0, 1, 0, 0), 0, 0, 0, 1, 32'h5A5A5A5A};
        vecs[9] = '{mk(1, 1, 4'b0000, 32'h400,     32'h87654321, 32'h0,       5, 0, 0, 0), 5, 4, 1, 0, 32'h5A5A5A5A};

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, b, r, e);
            model(vecs[i].op);
            check($sformatf("vec%0d_busy", i), b, vecs[i].e_busy);
            check($sformatf("vec%0d_req", i), r, vecs[i].e_req);
            check($sformatf("vec%0d_err", i), e, vecs[i].e_err);
            check($sformatf("vec%0d_RegWriteM", i), RegWriteM, vecs[i].e_rw);
            check($sformatf("vec%0d_ReadDataM", i), ReadDataM, vecs[i].e_rd);
            if (!vecs[i].op.flush && !vecs[i].op.stall)
                check($sformatf("vec%0d_ALUMultOutM", i), ALUMultOutM, vecs[i].op.alu);
        end

        // Reset two cycles into an access: request drops asynchronously, access is discarded.
        op = mk(1, 0, 4'b0011, 32'h500, 32'h0, 32'h33333333, 0, 0, 0, 0);
        RegWriteE = 1'b1; MemWriteE = 1'b0; MemtoRegE = 4'b0011; ALUMultOutE = 32'h500;
        step();
        check("mid_req_start", dmem_req, 1);
        step();
        step();
        check("mid_busy_before", memBusyM, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req", dmem_req, 0);
        check("mid_rst_busy", memBusyM, 0);
        check("mid_rst_ReadDataM", ReadDataM, 0);
        m_rw = 1'b0; m_rd = '0; m_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        op = mk(1, 0, 4'b0000, 32'h0000ABCD, 32'h0, 32'h0, 0, 0, 0, 0);
        do_op(op, b, r, e);
        model(op);
        check("post_rst_add_busy", b, 0);
        check_fields("post_rst_add");

        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 3);
            op.stall = ($urandom_range(0, 7) == 0);
            op.flush = ($urandom_range(0, 7) == 0);
            op.noise = ($urandom_range(0, 3) == 0);
            op.rw    = (kind != 2) ? 1'b1 : $urandom_range(0, 1);
            op.mw    = (kind == 2);
            op.jmp   = (kind == 3);
            op.mtr   = 4'($urandom_range(0, 15));
            if (kind == 1) op.mtr[1:0] = 2'b11;
            else           op.mtr[1:0] = 2'($urandom_range(0, 2));
            op.wr    = 5'($urandom_range(0, 31));
            op.alu   = $urandom;
            op.wd    = $urandom;
            op.pc8   = $urandom;
            op.rdata = $urandom;
            op.delay = $urandom_range(0, 6);
            do_op(op, b, r, e);
            model(op);
            check($sformatf("rnd%0d_busy", n), b, x_busy);
            check($sformatf("rnd%0d_req", n), r, x_req);
            check($sformatf("rnd%0d_err", n), e, x_err);
            check_fields($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
